// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, state encoding and index helpers for the FFT front end.
package fft_pkg;

    localparam int FFT_SIZE_D    = 16;
    localparam int WORD_SIZE_D   = 16;
    localparam int DATA_LENGTH_D = 8;
    localparam int STAGES_D      = 4;
    localparam int BYTES_PER_WORD = WORD_SIZE_D / DATA_LENGTH_D;

    typedef enum logic {S_FILL, S_DRAIN} state_t;

    function automatic logic [31:0] bitrev(input logic [31:0] idx, input int stages);
        logic [31:0] v;
        logic [31:0] r;
        v = idx;
        r = '0;
        for (int i = 0; i < stages; i++) begin
            r = {r[30:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sample_loader.sv
// fft_sample_loader: packs UART bytes into big-endian samples, buffers one frame and streams it
// to the FFT in natural or bit-reversed order; bytes arriving while draining are dropped and flagged.
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter int FFT_SIZE    = FFT_SIZE_D,
    parameter int WORD_SIZE   = WORD_SIZE_D,
    parameter int DATA_LENGTH = DATA_LENGTH_D,
    parameter int STAGES      = STAGES_D,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [DATA_LENGTH-1:0] i_rx_byte,
    input  logic                   i_rx_valid,
    input  logic                   i_rx_error,
    output logic [WORD_SIZE-1:0]   o_sample,
    output logic                   o_sample_valid,
    input  logic                   i_sample_ready,
    output logic [STAGES-1:0]      o_sample_index,
    output logic                   o_frame_last,
    output logic                   o_busy,
    output logic                   o_overrun
);

    localparam int BPW = WORD_SIZE / DATA_LENGTH;
    localparam int BW  = BPW > 1 ? $clog2(BPW) : 1;

    state_t                state, state_nxt;
    logic [BW-1:0]         byte_cnt;
    logic [STAGES-1:0]     wr_cnt, rd_cnt, rd_idx;
    logic [WORD_SIZE-1:0]  asm_word, word_nxt;
    logic [WORD_SIZE-1:0]  mem [FFT_SIZE];
    logic                  drain, take, word_done, xfer, rd_last, overrun;

    assign drain     = state == S_DRAIN;
    assign take      = !drain && i_rx_valid && !i_rx_error;
    assign word_done = take && byte_cnt == BW'(BPW - 1);
    assign xfer      = drain && i_sample_ready;
    assign rd_last   = rd_cnt == STAGES'(FFT_SIZE - 1);
    assign word_nxt  = WORD_SIZE'(asm_word << DATA_LENGTH) | WORD_SIZE'(i_rx_byte);
    assign rd_idx    = BIT_REVERSE ? STAGES'(bitrev(32'(rd_cnt), STAGES)) : rd_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_FILL;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!drain && word_done && wr_cnt == STAGES'(FFT_SIZE - 1)) state_nxt = S_DRAIN;
        if (xfer && rd_last) state_nxt = S_FILL;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            byte_cnt <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            asm_word <= '0;
            overrun  <= 1'b0;
        end else begin
            overrun <= drain && i_rx_valid;
            if (!drain && i_rx_error) begin
                byte_cnt <= '0;
            end else if (take) begin
                asm_word <= word_nxt;
                byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
            end
            // Counters wrap naturally because FFT_SIZE is a power of two.
            if (word_done) wr_cnt <= wr_cnt + 1'b1;
            if (xfer) rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (word_done) mem[wr_cnt] <= word_nxt;
    end

    assign o_sample_valid = drain;
    assign o_busy         = drain;
    assign o_sample_index = drain ? rd_idx : '0;
    assign o_sample       = drain ? mem[rd_idx] : '0;
    assign o_frame_last   = drain && rd_last;
    assign o_overrun      = overrun;

endmodule

// File: tb/tb_fft_sample_loader.sv
// tb_fft_sample_loader: randomized and directed checks of bit-reversed and natural-order loaders
// against a frame-level reference model.
module tb_fft_sample_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0, rx_error = 1'b0, ready = 1'b0;

    logic [15:0] a_sample, b_sample;
    logic [3:0]  a_index, b_index;
    logic        a_valid, b_valid, a_last, b_last, a_busy, b_busy, a_ovr, b_ovr;

    fft_sample_loader #(.BIT_REVERSE(1'b1)) dut_rev (
        .i_clk(clk), .i_rst(rst), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid), .i_rx_error(rx_error),
        .o_sample(a_sample), .o_sample_valid(a_valid), .i_sample_ready(ready),
        .o_sample_index(a_index), .o_frame_last(a_last), .o_busy(a_busy), .o_overrun(a_ovr)
    );

    fft_sample_loader #(.BIT_REVERSE(1'b0)) dut_nat (
        .i_clk(clk), .i_rst(rst), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid), .i_rx_error(rx_error),
        .o_sample(b_sample), .o_sample_valid(b_valid), .i_sample_ready(ready),
        .o_sample_index(b_index), .o_frame_last(b_last), .o_busy(b_busy), .o_overrun(b_ovr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bit          drain, ovr;
    int          rd, wr;
    logic [7:0]  pend [$];
    logic [15:0] frame [16];

    function automatic int rev4(input int n);
        return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
    endfunction

    task automatic model_reset();
        drain = 0; ovr = 0; rd = 0; wr = 0;
        pend.delete();
    endtask

    task automatic compare();
        int ia, ib;
        ia = drain ? rev4(rd) : 0;
        ib = drain ? rd : 0;
        check("rev_valid", a_valid, drain);
        check("rev_index", a_index, ia);
        check("rev_sample", a_sample, drain ? frame[ia] : 16'h0);
        check("rev_last", a_last, drain && rd == 15);
        check("rev_busy", a_busy, drain);
        check("rev_overrun", a_ovr, ovr);
        check("nat_valid", b_valid, drain);
        check("nat_index", b_index, ib);
        check("nat_sample", b_sample, drain ? frame[ib] : 16'h0);
        check("nat_last", b_last, drain && rd == 15);
        check("nat_busy", b_busy, drain);
        check("nat_overrun", b_ovr, ovr);
    endtask

    task automatic cycle(input bit v, input bit e, input logic [7:0] b, input bit r);
        @(negedge clk);
        compare();
        rx_valid = v; rx_error = e; rx_byte = b; ready = r;
        ovr = drain && v;
        if (drain) begin
            if (r) begin
                if (rd == 15) begin rd = 0; drain = 0; end
                else rd++;
            end
        end else if (e) begin
            pend.delete();
        end else if (v) begin
            pend.push_back(b);
            if (pend.size() == 2) begin
                frame[wr] = {pend[0], pend[1]};
                pend.delete();
                if (wr == 15) begin wr = 0; drain = 1; end
                else wr++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        rx_valid = 0; rx_error = 0; ready = 0;
        model_reset();
        #1 compare();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit r);
        cycle(1, 0, w[15:8], r);
        cycle(1, 0, w[7:0], r);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ordered frame, ready held high
        for (int i = 0; i < 16; i++) send_word(16'(i), 1);
        repeat (18) cycle(0, 0, 8'h00, 1);

        // ordered frame, ready toggling every cycle
        for (int i = 0; i < 16; i++) send_word(16'(i), 1);
        for (int i = 0; i < 36; i++) cycle(0, 0, 8'h00, i[0]);

        // framing error discards a partial word only
        cycle(1, 0, 8'h12, 0);
        cycle(0, 1, 8'h00, 0);
        send_word(16'h3456, 0);
        for (int i = 1; i < 16; i++) send_word(16'($urandom), 0);

        // overrun bytes while stalled in drain, then drain the untouched frame
        cycle(1, 0, 8'hAA, 0);
        cycle(0, 0, 8'h00, 0);
        cycle(1, 1, 8'hBB, 0);
        cycle(1, 0, 8'hCC, 0);
        repeat (20) cycle(0, 0, 8'h00, 1);
        for (int i = 0; i < 16; i++) send_word(16'($urandom), 1);
        repeat (18) cycle(0, 0, 8'h00, 1);

        // resets after 7 stored words and mid-drain
        for (int i = 0; i < 7; i++) send_word(16'($urandom), 0);
        do_reset();
        for (int i = 0; i < 16; i++) send_word(16'($urandom), 0);
        repeat (5) cycle(0, 0, 8'h00, 1);
        do_reset();
        for (int i = 0; i < 16; i++) send_word(16'($urandom), 0);
        repeat (18) cycle(0, 0, 8'h00, 1);

        // last transfer coinciding with an incoming byte
        for (int i = 0; i < 16; i++) send_word(16'($urandom), 1);
        repeat (15) cycle(0, 0, 8'h00, 1);
        cycle(1, 0, 8'h77, 1);
        repeat (3) cycle(0, 0, 8'h00, 1);
        do_reset();

        // back-to-back frames of 0x31 at full byte rate
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 32; i++) cycle(1, 0, 8'h31, 1);
            for (int i = 0; i < 17; i++) begin
                cycle(1, 0, 8'h31, 1);
                if (a_valid) check("pattern_3131", a_sample, 16'h3131);
            end
            pend.delete();
            do_reset();
        end

        // random traffic
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 1), $urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 2) != 0);
        cycle(0, 0, 8'h00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
